prog_clk_gen: RTL and testbench

Parametrised multi-channel successor of the single-channel programmable clock divider. It derives one base clock from the 100 MHz system clock, plus N_CH independently programmable slow clocks, each a power-of-two division of the base clock. Per-channel mode changes are queued and applied only at a glitch-free switch point, so an update never produces a runt pulse. It sits between the system clock domain and the slow-rate timing logic (blinkers, counters, display scan).

---
 rtl/prog_clk_pkg.sv | 23 ++
 rtl/prog_clk_ch.sv | 76 +++++++
 rtl/prog_clk_gen.sv | 94 +++++++++
 tb/tb_prog_clk_gen.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clk_pkg.sv
// ============================================================================
// Module  : prog_clk_pkg
// Purpose : Shared constants and helpers for the programmable clock generator.
// Rev     : 1.0  initial multi-channel release
// ============================================================================
`default_nettype none

package prog_clk_pkg;

   localparam int c_sel_w_default = 3;

   // Divider width: one divider bit per selectable mode.
   function automatic int div_w(input int sel_w);
      return 1 << sel_w;
   endfunction

   function automatic int unsigned max_sel(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prog_clk_ch.sv
// ============================================================================
// Module  : prog_clk_ch
// Purpose : One slow-clock channel: request queue, glitch-free mode switch
//           and the registered channel clock.
// Rev     : 1.0  initial multi-channel release
// ============================================================================
`default_nettype none

module prog_clk_ch
   import prog_clk_pkg::*;
#(
   parameter int SEL_W   = c_sel_w_default,
   parameter int RST_SEL = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [div_w(SEL_W)-1:0]  div_cnt_next,
   input  logic                     inc,
   input  logic                     req,
   input  logic [SEL_W-1:0]         req_sel,
   output logic                     ch_clk,
   output logic [SEL_W-1:0]         mode,
   output logic                     pending
);

   localparam int c_div_w = div_w(SEL_W);

   logic [SEL_W-1:0] r_target;
   logic [SEL_W-1:0] r_mode;
   logic             r_pending;
   logic             r_ch_clk;

   int unsigned      w_m;
   logic             w_low_zero;
   logic             w_apply;
   logic [SEL_W-1:0] w_mode_next;

   // Both old and new clocks are low at a fresh period when bits [m:0] are zero.
   always_comb begin
      w_m        = max_sel(32'(r_mode), 32'(r_target));
      w_low_zero = 1'b1;
      for (int unsigned b = 0; b < c_div_w; b++) begin
         if (b <= w_m && div_cnt_next[b]) begin
            w_low_zero = 1'b0;
         end
      end
   end

   assign w_apply     = inc && r_pending && w_low_zero && !req;
   assign w_mode_next = w_apply ? r_target : r_mode;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_target  <= SEL_W'(RST_SEL);
         r_mode    <= SEL_W'(RST_SEL);
         r_pending <= 1'b0;
         r_ch_clk  <= 1'b0;
      end else begin
         if (req) begin
            r_target  <= req_sel;
            r_pending <= 1'b1;
         end else if (w_apply) begin
            r_pending <= 1'b0;
         end
         r_mode   <= w_mode_next;
         r_ch_clk <= div_cnt_next[w_mode_next];
      end
   end

   assign ch_clk  = r_ch_clk;
   assign mode    = r_mode;
   assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/prog_clk_gen.sv
// ============================================================================
// Module  : prog_clk_gen
// Purpose : Base clock prescaler, shared power-of-two divider and N_CH
//           independently programmable slow-clock channels.
// Rev     : 1.0  initial multi-channel release
// ============================================================================
`default_nettype none

module prog_clk_gen
   import prog_clk_pkg::*;
#(
   parameter int HALF_PERIOD_CNT = 2,
   parameter int N_CH            = 2,
   parameter int SEL_W           = c_sel_w_default,
   parameter int RST_SEL         = 0
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  update,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
   input  logic [SEL_W-1:0]                      prog_in,
   output logic                                  base_clk,
   output logic                                  base_tick,
   output logic [N_CH-1:0]                       ch_clk,
   output logic [N_CH*SEL_W-1:0]                 prog_out,
   output logic [N_CH-1:0]                       pending
);

   localparam int c_div_w = div_w(SEL_W);
   localparam int c_pre_w = (HALF_PERIOD_CNT > 1) ? $clog2(HALF_PERIOD_CNT) : 1;
   localparam int c_ch_w  = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [c_pre_w-1:0] r_pre_cnt;
   logic               r_base_clk;
   logic               r_base_tick;
   logic [c_div_w-1:0] r_div_cnt;

   logic               w_pre_term;
   logic               w_inc;
   logic [c_div_w-1:0] w_div_next;

   assign w_pre_term = (r_pre_cnt == c_pre_w'(HALF_PERIOD_CNT - 1));
   // The divider advances only on base_clk rising transitions.
   assign w_inc      = w_pre_term && !r_base_clk;
   assign w_div_next = w_inc ? r_div_cnt + 1'b1 : r_div_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre_cnt   <= '0;
         r_base_clk  <= 1'b0;
         r_base_tick <= 1'b0;
         r_div_cnt   <= '0;
      end else begin
         r_base_tick <= w_inc;
         r_div_cnt   <= w_div_next;
         if (w_pre_term) begin
            r_pre_cnt  <= '0;
            r_base_clk <= ~r_base_clk;
         end else begin
            r_pre_cnt  <= r_pre_cnt + 1'b1;
         end
      end
   end

   assign base_clk  = r_base_clk;
   assign base_tick = r_base_tick;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic w_req;

         // Out-of-range selectors never match any channel and are dropped.
         assign w_req = update && (ch_sel == c_ch_w'(i));

         prog_clk_ch #(
            .SEL_W   (SEL_W),
            .RST_SEL (RST_SEL)
         ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .div_cnt_next (w_div_next),
            .inc          (w_inc),
            .req          (w_req),
            .req_sel      (prog_in),
            .ch_clk       (ch_clk[i]),
            .mode         (prog_out[i*SEL_W +: SEL_W]),
            .pending      (pending[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_prog_clk_gen.sv
// ============================================================================
// Module  : tb_prog_clk_gen
// Purpose : Directed plus randomized check of prog_clk_gen against a
//           cycle-count based reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_clk_gen;

   localparam int HALF  = 2;
   localparam int NCH   = 3;
   localparam int SW    = 3;
   localparam int DW    = 8;
   localparam int RS    = 0;
   localparam int CW    = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              update = 1'b0;
   logic [CW-1:0]     ch_sel = '0;
   logic [SW-1:0]     prog_in = '0;
   logic              base_clk;
   logic              base_tick;
   logic [NCH-1:0]    ch_clk;
   logic [NCH*SW-1:0] prog_out;
   logic [NCH-1:0]    pending;

   prog_clk_gen #(
      .HALF_PERIOD_CNT (HALF),
      .N_CH            (NCH),
      .SEL_W           (SW),
      .RST_SEL         (RS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .update    (update),
      .ch_sel    (ch_sel),
      .prog_in   (prog_in),
      .base_clk  (base_clk),
      .base_tick (base_tick),
      .ch_clk    (ch_clk),
      .prog_out  (prog_out),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   // Model state: edges since reset release plus per-channel mode/target/pending.
   int cyc;
   int m_mode [NCH];
   int m_tgt  [NCH];
   bit m_pend [NCH];
   int checks = 0;
   int errors = 0;

   function automatic int div_at(input int c);
      return ((c + HALF) / (2 * HALF)) % (1 << DW);
   endfunction

   function automatic bit tick_at(input int c);
      return (c > 0) && ((c % (2 * HALF)) == HALF);
   endfunction

   function automatic bit sw_next(input int ch);
      int c, m;
      c = cyc + 1;
      if (!tick_at(c) || !m_pend[ch]) return 1'b0;
      m = (m_mode[ch] > m_tgt[ch]) ? m_mode[ch] : m_tgt[ch];
      return (div_at(c) % (1 << (m + 1))) == 0;
   endfunction

   task automatic model_edge(input bit r, input bit u, input int s, input int v);
      bit sw [NCH];
      if (r) begin
         cyc = 0;
         for (int ch = 0; ch < NCH; ch++) begin
            m_mode[ch] = RS;
            m_tgt[ch]  = RS;
            m_pend[ch] = 1'b0;
         end
      end else begin
         for (int ch = 0; ch < NCH; ch++) sw[ch] = sw_next(ch);
         cyc++;
         for (int ch = 0; ch < NCH; ch++) begin
            if (u && s == ch) begin
               m_tgt[ch]  = v;
               m_pend[ch] = 1'b1;
            end else if (sw[ch]) begin
               m_mode[ch] = m_tgt[ch];
               m_pend[ch] = 1'b0;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic check_all();
      chk("base_clk", 32'(base_clk), 32'(((cyc + HALF) % (2 * HALF)) < HALF));
      chk("base_tick", 32'(base_tick), 32'(tick_at(cyc)));
      for (int ch = 0; ch < NCH; ch++) begin
         chk("ch_clk", 32'(ch_clk[ch]), 32'((div_at(cyc) >> m_mode[ch]) & 1));
         chk("prog_out", 32'(prog_out[ch*SW +: SW]), 32'(m_mode[ch]));
         chk("pending", 32'(pending[ch]), 32'(m_pend[ch]));
      end
   endtask

   task automatic step(input bit r, input bit u, input int s, input int v);
      logic [31:0] sv, vv;
      sv = s;
      vv = v;
      rst     = r;
      update  = u;
      ch_sel  = sv[CW-1:0];
      prog_in = vv[SW-1:0];
      @(posedge clk);
      model_edge(r, u, s, v);
      #1;
      check_all();
   endtask

   task automatic wait_clear(input int ch, input int budget);
      int n;
      n = 0;
      while (m_pend[ch] && n < budget) begin
         step(0, 0, 0, 0);
         n++;
      end
      chk("apply_timeout", 32'(m_pend[ch]), 32'(0));
   endtask

   initial begin
      int n, cnt;
      logic prev;

      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      chk("rst_prog_out", 32'(prog_out), 32'(0));
      chk("rst_pending", 32'(pending), 32'(0));
      chk("rst_ch_clk", 32'(ch_clk), 32'(0));

      // First base_tick lands HALF cycles after release.
      for (int i = 0; i < 12; i++) step(0, 0, 0, 0);

      // Ch0 0->2 requested at div_cnt 5; switch at 8, then clean 16/16 cycle halves.
      n = 0;
      while (div_at(cyc) != 5 && n < 200) begin step(0, 0, 0, 0); n++; end
      step(0, 1, 0, 2);
      chk("req_pending0", 32'(pending[0]), 32'(1));
      n = 0;
      while (m_pend[0] && n < 200) begin step(0, 0, 0, 0); n++; end
      chk("apply_mode2", 32'(prog_out[2:0]), 32'(2));
      cnt = 1;
      n = 0;
      while (n < 100) begin
         step(0, 0, 0, 0); n++;
         if (ch_clk[0] !== 1'b0) break;
         cnt++;
      end
      chk("low_run", 32'(cnt), 32'(16));
      cnt = 1;
      n = 0;
      while (n < 100) begin
         step(0, 0, 0, 0); n++;
         if (ch_clk[0] !== 1'b1) break;
         cnt++;
      end
      chk("high_run", 32'(cnt), 32'(16));

      // Ch1: mode 3, then back-to-back 5 and 1, last one wins.
      step(0, 1, 1, 3);
      wait_clear(1, 400);
      step(0, 1, 1, 5);
      step(0, 1, 1, 1);
      wait_clear(1, 400);
      chk("last_wins", 32'(prog_out[5:3]), 32'(1));

      // Update landing exactly on the switch-point cycle wins over the apply.
      step(0, 1, 1, 2);
      n = 0;
      while (!sw_next(1) && n < 400) begin step(0, 0, 0, 0); n++; end
      step(0, 1, 1, 4);
      chk("collide_pending", 32'(pending[1]), 32'(1));
      chk("collide_mode", 32'(prog_out[5:3]), 32'(1));
      wait_clear(1, 800);
      chk("collide_apply4", 32'(prog_out[5:3]), 32'(4));

      // Out-of-range selector, then reset while a request is pending.
      step(0, 1, 3, 6);
      step(0, 1, 0, 5);
      chk("pend_before_rst", 32'(pending[0]), 32'(1));
      step(1, 0, 0, 0);
      chk("rst_mid_prog", 32'(prog_out), 32'(0));
      chk("rst_mid_pend", 32'(pending), 32'(0));

      // Mode 7 then 7->0: applies on the 255->0 wrap with ch_clk falling.
      step(0, 1, 0, 7);
      wait_clear(0, 1200);
      step(0, 1, 0, 0);
      prev = ch_clk[0];
      n = 0;
      while (m_pend[0] && n < 1200) begin
         prev = ch_clk[0];
         step(0, 0, 0, 0);
         n++;
      end
      chk("wrap_prev_high", 32'(prev), 32'(1));
      chk("wrap_clk_low", 32'(ch_clk[0]), 32'(0));
      chk("wrap_mode0", 32'(prog_out[2:0]), 32'(0));

      // Randomized traffic including invalid selectors and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom % 700) == 0, ($urandom % 6) == 0,
              int'($urandom % 4), int'($urandom % 8));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
